// File: rtl/trajectory_gen.sv
// Synthesises a ballistic pixel trajectory from a launch point and per-frame velocity,
// emitting one on-screen position per video frame tick under constant downward gravity.
module trajectory_gen #(
   parameter int unsigned H_RES      = 1280,
   parameter int unsigned V_RES      = 720,
   parameter int unsigned FRAC       = 8,
   parameter int unsigned GRAVITY    = 32,
   parameter int unsigned MAX_FRAMES = 1023
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        start_valid_in,
   input  logic [10:0] x0_in,
   input  logic [9:0]  y0_in,
   input  logic [15:0] vx_in,
   input  logic [15:0] vy_in,
   input  logic        is_vy_neg_in,
   input  logic        frame_tick_in,
   input  logic        abort_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic        pos_valid_out,
   output logic [9:0]  frame_idx_out,
   output logic        active_out,
   output logic        done_out
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [11:0] HLim   = 12'(H_RES);
   localparam logic [11:0] VLim   = 12'(V_RES);
   localparam logic [9:0]  MaxCnt = 10'(MAX_FRAMES);
   localparam logic [20:0] Grav   = 21'(GRAVITY);

   state_e             state_q, state_d;
   logic signed [20:0] px_q, px_d, py_q, py_d, vxq_q, vxq_d, vyq_q, vyq_d;
   logic        [9:0]  count_q, count_d;
   logic        [10:0] x_q, x_d;
   logic        [9:0]  y_q, y_d, idx_q, idx_d;
   logic               pos_valid_q, pos_valid_d, done_q, done_d;

   logic        [10:0] vx_sat, vy_sat;
   logic signed [20:0] vy_mag, px_n, py_n;
   logic        [9:0]  count_n;
   logic               launch_on, step_on;

   // Magnitudes above 2047 px/frame clamp rather than wrap.
   assign vx_sat    = (|vx_in[15:11]) ? 11'd2047 : vx_in[10:0];
   assign vy_sat    = (|vy_in[15:11]) ? 11'd2047 : vy_in[10:0];
   assign vy_mag    = {2'b00, vy_sat, 8'h00};
   assign launch_on = ({1'b0, x0_in} < HLim) && ({2'b00, y0_in} < VLim);

   assign px_n    = px_q + vxq_q;
   assign py_n    = py_q + vyq_q;
   assign count_n = count_q + 10'd1;
   // Integer part is the floor; any negative position is off-screen.
   assign step_on = !px_n[20] && (px_n[19:8] < HLim) && !py_n[20] && (py_n[19:8] < VLim);

   always_comb begin
      state_d     = state_q;
      px_d        = px_q;
      py_d        = py_q;
      vxq_d       = vxq_q;
      vyq_d       = vyq_q;
      count_d     = count_q;
      x_d         = x_q;
      y_d         = y_q;
      idx_d       = idx_q;
      pos_valid_d = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_valid_in) begin
               px_d    = {2'b00, x0_in, 8'h00};
               py_d    = {3'b000, y0_in, 8'h00};
               vxq_d   = {2'b00, vx_sat, 8'h00};
               vyq_d   = is_vy_neg_in ? -vy_mag : vy_mag;
               count_d = 10'd0;
               if (launch_on) begin
                  state_d     = StRun;
                  pos_valid_d = 1'b1;
                  x_d         = x0_in;
                  y_d         = y0_in;
                  idx_d       = 10'd0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (abort_in) begin
               state_d = StIdle;
            end else if (frame_tick_in) begin
               px_d    = px_n;
               py_d    = py_n;
               vyq_d   = vyq_q + Grav;
               count_d = count_n;
               if (step_on) begin
                  pos_valid_d = 1'b1;
                  x_d         = px_n[18:8];
                  y_d         = py_n[17:8];
                  idx_d       = count_n;
                  if (count_n == MaxCnt) begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end
               end else begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= StIdle;
         px_q        <= '0;
         py_q        <= '0;
         vxq_q       <= '0;
         vyq_q       <= '0;
         count_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         idx_q       <= '0;
         pos_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         px_q        <= px_d;
         py_q        <= py_d;
         vxq_q       <= vxq_d;
         vyq_q       <= vyq_d;
         count_q     <= count_d;
         x_q         <= x_d;
         y_q         <= y_d;
         idx_q       <= idx_d;
         pos_valid_q <= pos_valid_d;
         done_q      <= done_d;
      end
   end

   assign x_out         = x_q;
   assign y_out         = y_q;
   assign frame_idx_out = idx_q;
   assign pos_valid_out = pos_valid_q;
   assign done_out      = done_q;
   assign active_out    = (state_q == StRun);

endmodule

// File: doc/trajectory_gen.md
Name: trajectory_gen

Overview:
- Reverse of the light-tracking velocity measurement path: takes a launch point and per-frame velocity (pixels/frame, unsigned magnitude plus a y-sign flag) and synthesises the pixel trajectory one position per video frame.
- Applies constant downward gravity in fixed point.
- Sits between the velocity measurement output and the sprite/overlay renderer, which draws a marker at each emitted position.

Parameters:
- H_RES, 1280, horizontal active pixels; x ≥ H_RES is off-screen.
- V_RES, 720, vertical active pixels; y ≥ V_RES is off-screen.
- FRAC, 8, fractional bits of the internal position and velocity.
- GRAVITY, 32, per-frame increment of vy in units of 2^-FRAC px/frame (+y is down the screen).
- MAX_FRAMES, 1023, maximum ticks per run before forced termination.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, asynchronous active-low reset.
- start_valid_in, input, 1, launch request; accepted only in IDLE.
- x0_in, input, 11, launch x (pixels).
- y0_in, input, 10, launch y (pixels).
- vx_in, input, 16, x velocity magnitude (px/frame, always rightward).
- vy_in, input, 16, y velocity magnitude (px/frame).
- is_vy_neg_in, input, 1, 1 means vy is upward (negative y).
- frame_tick_in, input, 1, one-cycle pulse per video frame.
- abort_in, input, 1, cancel the run.
- x_out, output, 11, current integer x.
- y_out, output, 10, current integer y.
- pos_valid_out, output, 1, one-cycle pulse; x_out/y_out hold a new on-screen position.
- frame_idx_out, output, 10, tick count of the emitted position (0 = launch point).
- active_out, output, 1, high in RUN.
- done_out, output, 1, one-cycle pulse when a run terminates naturally.

Behaviour:
- Reset (async, rst_n_in low): state=IDLE. All outputs 0. Internal px, py, vxq, vyq and count all 0.
- Internal registers:
  - px, py: signed 21-bit, 12 integer + FRAC.
  - vxq, vyq: signed 21-bit.
  - count: 10-bit.
- IDLE + start_valid_in:
  - Saturate each velocity magnitude to 2047 when bits [15:11] are nonzero.
  - Load px=x0<<FRAC, py=y0<<FRAC, vxq=vx<<FRAC, vyq=±vy<<FRAC (negated when is_vy_neg_in=1), count=0.
  - If x0_in ≥ H_RES or y0_in ≥ V_RES: no pos_valid_out; done_out pulses the next cycle; stay IDLE.
  - Otherwise: go to RUN, active_out=1, and next cycle pos_valid_out=1 with x_out=x0, y_out=y0, frame_idx_out=0.
  - A frame_tick_in in the acceptance cycle is ignored.
- RUN + frame_tick_in (latency 1, all updates on the same edge):
  - px' = px+vxq; py' = py+vyq (old vyq is used); vyq' = vyq+GRAVITY; count' = count+1.
  - On-screen test uses the integer part (arithmetic shift, floor). It is on-screen iff px'≥0, px'>>FRAC < H_RES, py'≥0 and py'>>FRAC < V_RES.
  - On-screen and count' < MAX_FRAMES: pos_valid_out=1, x_out/y_out = integer parts, frame_idx_out=count'.
  - On-screen and count' == MAX_FRAMES: the position is emitted, done_out pulses in the same cycle, go to IDLE.
  - Off-screen: no pos_valid_out; x_out/y_out keep their last values; done_out=1; go to IDLE; active_out=0.
- start_valid_in in RUN is ignored; the request is not queued.
- abort_in in RUN: go to IDLE next edge, active_out=0, no done_out, no pos_valid_out. Abort wins over a simultaneous tick. abort_in in IDLE has no effect.
- pos_valid_out and done_out are single-cycle pulses and never stretch.
- frame_tick_in in IDLE is ignored.
- Reset mid-run returns to IDLE immediately and all pulses drop asynchronously.

Test Plan:
1. GRAVITY=256; start x0=100, y0=400, vx=10, vy=20, is_vy_neg=1. Expected:
   - frame 0 = (100,400).
   - tick1 = (110,380), idx1.
   - tick2 = (120,361).
   - tick3 = (130,343).
   - tick4 = (140,326).
2. Default GRAVITY; x0=1275, y0=300, vx=10, vy=0; one tick. Expected: frame 0 = (1275,300) emitted; on the tick, no pos_valid, done_out pulse, active_out=0.
3. GRAVITY=256; x0=50, y0=5, vx=0, vy=10 up; one tick. Expected: py'<0 → off-screen, done_out, no emission.
4. vx_in=16'h1000 at x0=0 → saturated to 2047. Expected: first tick is off-screen (2047 ≥ 1280), done_out.
5. Mid-run behaviour:
   - Assert start_valid_in in RUN. Expected: ignored, trajectory unchanged.
   - Assert abort_in and frame_tick_in in the same cycle. Expected: IDLE, no pos_valid, no done_out.
   - Pull rst_n_in low between ticks. Expected: outputs 0 asynchronously.
6. MAX_FRAMES=3, vx=1, vy=0, x0=10, y0=10. Expected: tick3 emits (13,10) with idx3 and done_out in the same cycle; a fourth tick produces nothing.
